sap_prog_loader: RTL and testbench
==================================

// Module: sap_prog_loader
// PURPOSE
//  Upstream loader for the SAP machine. Takes a byte stream (valid/ready) from
//  the host/switch interface and writes it into the 16x8 program memory read
//  by the ROM stage at word addresses 0..LOAD_LEN-1.
//  Holds the CPU in clear while loading and releases it once the image is complete.
// PARAMETERS
//  ADDR_W    4   program memory address width
//  DATA_W    8   byte/word width, equal to the bus width
//  LOAD_LEN  16  words per image, 1..2**ADDR_W
// PORTS
//  CLK        in   1       system clock, rising edge
//  CLR        in   1       asynchronous active-high reset
//  start      in   1       one-cycle pulse: begin a new image load
//  in_valid   in   1       host byte valid
//  in_data    in   DATA_W  host byte
//  in_ready   out  1       loader accepts a byte (combinational: state==LOAD)
//  mem_we     out  1       program memory write strobe, one cycle per word
//  mem_addr   out  ADDR_W  program memory write address
//  mem_wdata  out  DATA_W  program memory write data
//  cpu_clr    out  1       drives the CPU's CLR; 1 = CPU held in clear
//  done       out  1       image loaded, CPU running
//  err        out  1       checksum failure (LOADER_CHECKSUM_EN only, else 0)
// BEHAVIOUR
//  - Reset (async, CLR=1): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0,
//    cpu_clr=1, done=0, err=0, word count=0, checksum accumulator=0.
//  - States: IDLE, LOAD, CHECK (only with the macro), RUN, ERR.
//  - IDLE/RUN/ERR + start -> LOAD. Count=0, accumulator=0, done=0, err=0, cpu_clr=1.
//  - LOAD: a byte is accepted when in_valid & in_ready at a rising edge.
//    Next cycle: mem_we=1, mem_addr=count, mem_wdata=byte (latency 1). Then count++.
//    mem_we is never high for more than one consecutive cycle per accepted byte.
//  - in_valid gaps are allowed, with any length. Bytes presented outside LOAD
//    are ignored: in_ready=0, no write.
//  - Accepting word LOAD_LEN-1 -> RUN (or CHECK with the macro). The last
//    write occurs on the first cycle in the new state.
//  - cpu_clr falls on the edge after that write (2 cycles after the final
//    handshake). done rises on the same edge. The CPU never leaves clear
//    while a write is pending.
//  - start while in LOAD restarts the load: count=0, accumulator=0, and
//    in_data is not accepted that cycle. Words already written stay in memory
//    and are overwritten by the new image.
//  - start while in RUN reloads: cpu_clr=1 on the next edge, so the CPU is
//    halted and cleared.
//  - Address never wraps: count saturates at LOAD_LEN; no writes past LOAD_LEN-1.
//  - CLR asserted mid-load: everything returns to reset values immediately.
//    The partial image in memory is not erased.
//  - mem_addr/mem_wdata hold their last value while mem_we=0.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - The accumulator is the mod-2**DATA_W sum of all accepted image words.
//   - After LOAD_LEN words, state is CHECK with in_ready=1. One more byte is
//     accepted and is NOT written to memory.
//   - Byte == accumulator -> RUN, with release timing as above, counted from
//     the checksum handshake.
//   - Mismatch -> ERR: err=1, cpu_clr stays 1, done=0. Only start or CLR
//     leaves ERR.
//  LOADER_CHECKSUM_EN undefined:
//   - No CHECK or ERR state, no accumulator; err tied to 0.
//   - LOAD -> RUN directly after the last word.
// TESTING
//  1 Reset: CLR pulse mid-cycle -> cpu_clr=1, done=0, err=0, mem_we=0,
//    in_ready=0 at once.
//  2 Load 0x00..0x0F, back-to-back -> 16 writes addr i/data i on consecutive
//    cycles. cpu_clr=0 and done=1 two cycles after the 16th handshake.
//  3 Same image with random 0-5 cycle valid gaps -> identical writes, one
//    mem_we per byte.
//  4 start after the 7th byte, then 16 bytes 0xA0..0xAF -> writes restart at
//    addr 0; the CPU is released only after addr 15=0xAF.
//  5 Checksum enabled: bytes 0x00..0x0F, then 0x78 -> RUN, done=1.
//    Then 0x00..0x0F, then 0x77 -> err=1, cpu_clr=1, no 17th write.
//  6 start while in RUN, or CLR after the 10th byte -> cpu_clr=1 next
//    edge / immediately; count returns to 0.

Source files
------------

// File: rtl/sap_prog_loader.sv
// Program loader for the SAP machine: streams host bytes into the 16x8 program memory
// and holds the CPU in clear until the image is complete. Optional: LOADER_CHECKSUM_EN.
module sap_prog_loader #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LOAD_LEN = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_clr,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LOAD_LEN);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

    state_t             state, state_d;
    logic [CNT_W-1:0]   count, count_d;
    logic               we_d, clr_d, done_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]  acc, acc_d;
    logic               err_q, err_d;

    assign in_ready = (state == S_LOAD) || (state == S_CHECK);
    assign err      = err_q;
`else
    assign in_ready = (state == S_LOAD);
    assign err      = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= S_IDLE;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_clr   <= 1'b1;
            done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            acc       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            count     <= count_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            cpu_clr   <= clr_d;
            done      <= done_d;
`ifdef LOADER_CHECKSUM_EN
            acc       <= acc_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next state; the CPU is released one edge after entering RUN so the last write lands first
    always_comb begin
        state_d = state;
        count_d = count;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        clr_d   = cpu_clr;
        done_d  = done;
`ifdef LOADER_CHECKSUM_EN
        acc_d   = acc;
        err_d   = err_q;
`endif
        if (start) begin
            state_d = S_LOAD;
            count_d = '0;
            clr_d   = 1'b1;
            done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            acc_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid && (count != FULL)) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(count);
                        wdata_d = in_data;
                        count_d = count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        acc_d   = acc + in_data;
                        if (count == LAST) state_d = S_CHECK;
`else
                        if (count == LAST) state_d = S_RUN;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (in_valid) begin
                        if (in_data == acc) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
`endif
                S_RUN: begin
                    clr_d  = 1'b0;
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Directed bench for sap_prog_loader: vector table plus hand-written load sequences.
module tb_sap_prog_loader;

    logic       CLK, CLR, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, mem_we, cpu_clr, done, err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic [11:0] wq[$];

    typedef struct {
        logic       s;
        logic       v;
        logic [7:0] d;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       rdy;
        logic       clr;
        logic       dn;
    } vec_t;
    vec_t vt[10];

    sap_prog_loader dut (
        .CLK(CLK), .CLR(CLR), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_clr(cpu_clr), .done(done), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, sample #1 after the edge, log any memory write
    task automatic step(input logic s, input logic v, input logic [7:0] d);
        start = s; in_valid = v; in_data = d;
        @(posedge CLK); #1;
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] base, input int n, input int gapmax);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (gaps) step(1'b0, 1'b0, 8'hEE);
            step(1'b0, 1'b1, 8'(base + 8'(i)));
        end
    endtask

    // Called right after the final image byte's edge
    task automatic release_check(input logic [7:0] csum);
        chk("last_we", 32'(mem_we), 32'd1);
        chk("last_addr", 32'(mem_addr), 32'hF);
        chk("hold_clr", 32'(cpu_clr), 32'd1);
        chk("hold_done", 32'(done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        step(1'b0, 1'b1, csum);
        chk("csum_we", 32'(mem_we), 32'd0);
        chk("csum_clr", 32'(cpu_clr), 32'd1);
`else
        chk("csum_unused", 32'(csum), 32'(csum ^ 8'h00));
        n_chk--;
`endif
        step(1'b0, 1'b0, 8'h00);
        chk("rel_clr", 32'(cpu_clr), 32'd0);
        chk("rel_done", 32'(done), 32'd1);
        chk("rel_we", 32'(mem_we), 32'd0);
        chk("rel_err", 32'(err), 32'd0);
    endtask

    task automatic check_image(input int first, input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            if (first + i < wq.size()) begin
                chk($sformatf("wr_addr%0d", i), 32'(wq[first+i][11:8]), 32'(i));
                chk($sformatf("wr_data%0d", i), 32'(wq[first+i][7:0]), 32'(8'(base + 8'(i))));
            end
        end
    endtask

    task automatic clr_pulse();
        #2 CLR = 1'b1;
        #1;
        chk("clr_cpu_clr", 32'(cpu_clr), 32'd1);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_we", 32'(mem_we), 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        CLR = 1'b0;
    endtask

    function automatic logic [7:0] sum16(input logic [7:0] base);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + 8'(base + 8'(i));
        return s;
    endfunction

    initial begin
        //          s  v  d      we addr wdata  rdy clr dn
        vt[0] = '{1'b0, 1'b1, 8'h33, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 1'b1, 8'h44, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b1, 8'h5A, 1'b1, 4'd0, 8'h5A, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 8'hFF, 1'b0, 4'd0, 8'h5A, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b1, 8'h3C, 1'b1, 4'd1, 8'h3C, 1'b1, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 8'h3D, 1'b1, 4'd2, 8'h3D, 1'b1, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b1, 8'h77, 1'b0, 4'd2, 8'h3D, 1'b1, 1'b1, 1'b0};
        vt[8] = '{1'b0, 1'b1, 8'h11, 1'b1, 4'd0, 8'h11, 1'b1, 1'b1, 1'b0};
        vt[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h11, 1'b1, 1'b1, 1'b0};

        CLR = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_clr", 32'(cpu_clr), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        CLR = 1'b0;

        // Short vector table: ignore outside LOAD, gaps, hold, restart
        for (int i = 0; i < 10; i++) begin
            step(vt[i].s, vt[i].v, vt[i].d);
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].we));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vt[i].addr));
            chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].wdata));
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d_clr", i), 32'(cpu_clr), 32'(vt[i].clr));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].dn));
        end

        // Back-to-back image
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        load_bytes(8'h00, 16, 0);
        release_check(sum16(8'h00));
        chk("b2b_count", 32'(wq.size()), 32'd16);
        check_image(0, 8'h00);

        // Same image with random valid gaps
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        chk("reload_clr", 32'(cpu_clr), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        load_bytes(8'h00, 16, 5);
        release_check(sum16(8'h00));
        chk("gap_count", 32'(wq.size()), 32'd16);
        check_image(0, 8'h00);

        // Restart after 7 bytes; the byte in the start cycle is dropped
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        load_bytes(8'h00, 7, 0);
        step(1'b1, 1'b1, 8'h55);
        chk("restart_we", 32'(mem_we), 32'd0);
        load_bytes(8'hA0, 16, 0);
        release_check(sum16(8'hA0));
        chk("restart_count", 32'(wq.size()), 32'd23);
        for (int i = 0; i < 7; i++)
            if (i < wq.size()) chk($sformatf("pre_addr%0d", i), 32'(wq[i][11:8]), 32'(i));
        check_image(7, 8'hA0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum lands in ERR with no extra write
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        load_bytes(8'h00, 16, 0);
        step(1'b0, 1'b1, 8'h77);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_we", 32'(mem_we), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        chk("bad_err2", 32'(err), 32'd1);
        chk("bad_clr", 32'(cpu_clr), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_count", 32'(wq.size()), 32'd16);
        step(1'b1, 1'b0, 8'h00);
        load_bytes(8'h00, 16, 0);
        release_check(sum16(8'h00));
`endif

        // start while running halts the CPU and restarts at address 0
        step(1'b1, 1'b0, 8'h00);
        chk("run_start_clr", 32'(cpu_clr), 32'd1);
        chk("run_start_done", 32'(done), 32'd0);
        chk("run_start_rdy", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 8'h99);
        chk("run_restart_addr", 32'(mem_addr), 32'd0);
        chk("run_restart_data", 32'(mem_wdata), 32'h99);

        // CLR after the 10th byte, then a fresh load starts at address 0
        load_bytes(8'h01, 9, 0);
        chk("pre_clr_addr", 32'(mem_addr), 32'd9);
        clr_pulse();
        step(1'b0, 1'b1, 8'h66);
        chk("post_clr_we", 32'(mem_we), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h42);
        chk("post_clr_addr", 32'(mem_addr), 32'd0);
        chk("post_clr_data", 32'(mem_wdata), 32'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
